// File: rtl/spram_pkg.sv
// Shared constants for the single-port RAM request controller.
package spram_pkg;

  // Controller FSM encoding.
  typedef logic state_t;
  localparam state_t ST_INIT = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

  // Depth of the read-response buffer.
  localparam int RSP_DEPTH = 2;

endpackage

// File: rtl/spram_rsp_fifo.sv
// Two-entry synchronous FIFO that holds read data until the consumer takes it.
module spram_rsp_fifo
  import spram_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [RSP_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop frees a slot in the same cycle, so a push into a full FIFO is legal when popping.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign full  = (count == 2'(RSP_DEPTH));
  assign empty = (count == 2'd0);
  assign dout  = mem[rd_ptr];

  // Storage, pointers and occupancy; entries are zeroed on reset so the head reads 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RSP_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spram_req_ctrl.sv
// Valid/ready front end for a single-port RAM with a post-reset clear pass.
//
// Handshake semantics: a request transfers on a posedge where req_valid and
// req_ready are both high; a response transfers on a posedge where rsp_valid
// and rsp_ready are both high. req_ready depends combinationally on rsp_ready
// (a pop this cycle frees a credit for a read accepted this cycle).
module spram_req_ctrl
  import spram_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    ADDR_WIDTH     = 4,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0,
  parameter bit                    CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  init_done
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  clr_last;
  logic                  rd_pending;
  logic                  accept;
  logic                  rd_accept;
  logic                  pop;
  logic [1:0]            fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [2:0]            credit_use;

  assign clr_last  = (clr_cnt == {ADDR_WIDTH{1'b1}});
  assign accept    = req_valid & req_ready;
  assign rd_accept = accept & ~req_we;
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_valid = ~fifo_empty;

  // Slots committed after this cycle: buffered words plus the read in flight,
  // minus the word leaving now. A new request needs that to stay below depth.
  assign credit_use = {1'b0, fifo_count} + {2'b00, rd_pending} - {2'b00, pop};
  // The full term is implied by the count sum; it is kept explicit for clarity.
  assign req_ready  = (state == ST_RUN) & ~(fifo_full & ~pop)
                    & (credit_use < 3'(RSP_DEPTH));

  // Clear-pass sequencing and init_done flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_INIT;
      clr_cnt   <= '0;
      init_done <= 1'b0;
    end else if (state == ST_INIT) begin
      if (!CLEAR_ON_RESET || clr_last) begin
        state     <= ST_RUN;
        init_done <= 1'b1;
      end
      if (CLEAR_ON_RESET) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  // One-cycle read latency tracker: the RAM word is valid the cycle after acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_pending <= 1'b0;
    else     rd_pending <= rd_accept;
  end

  // RAM port mux: clear writes during INIT, pass-through of the request channel in RUN.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = req_addr;
    ram_din  = req_wdata;
    if (state == ST_INIT) begin
      if (CLEAR_ON_RESET) begin
        ram_we   = 1'b1;
        ram_addr = clr_cnt;
        ram_din  = INIT_VALUE;
      end
    end else begin
      ram_we = accept & req_we;
    end
    if (rst) ram_we = 1'b0;
  end

  spram_rsp_fifo #(
    .WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_pending),
    .pop   (pop),
    .din   (ram_dout),
    .dout  (rsp_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_spram_req_ctrl.sv
// Directed bench for spram_req_ctrl with a behavioural single-port RAM attached.
module tb_spram_req_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;
  logic       init_done;

  int n_tests = 0;
  int n_fail  = 0;

  // Clock.
  always #5 clk = ~clk;

  // Behavioural RAM, preloaded with 0xFF so the clear pass is observable.
  logic [7:0] mem [0:15] = '{default: 8'hFF};
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    else        ram_dout      <= mem[ram_addr];
  end

  spram_req_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .init_done (init_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [3:0] addr, input logic [7:0] data);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 4'h0;
    req_wdata = 8'h00;
  endtask

  // Expects 16 clear writes to addresses 0..15, then RUN with req_ready high.
  task automatic check_clear_pass();
    for (int i = 0; i < 16; i++) begin
      #1;
      check("clr_we", ram_we, 1);
      check("clr_addr", ram_addr, i);
      check("clr_din", ram_din, 0);
      check("clr_ready", req_ready, 0);
      check("clr_done", init_done, 0);
      check("clr_rsp_valid", rsp_valid, 0);
      @(negedge clk);
    end
    #1;
    check("init_done", init_done, 1);
    check("run_ready", req_ready, 1);
    check("run_we_idle", ram_we, 0);
  endtask

  initial begin
    rst       = 1'b1;
    rsp_ready = 1'b1;
    idle();

    // Reset values.
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_init_done", init_done, 0);
    check("rst_ram_we", ram_we, 0);

    // Clear pass.
    rst = 1'b0;
    check_clear_pass();

    // Read address 5 after clear: 0x00, valid one cycle after acceptance.
    @(negedge clk); drive(0, 4'd5, 8'h00); #1;
    check("rd5_ready", req_ready, 1);
    @(negedge clk); idle(); #1;
    check("rd5_lat_valid", rsp_valid, 0);
    @(negedge clk); #1;
    check("rd5_valid", rsp_valid, 1);
    check("rd5_data", rsp_rdata, 8'h00);
    @(negedge clk); #1;
    check("rd5_popped", rsp_valid, 0);

    // Write 0xA5 to 3 then read 3 on the next edge.
    @(negedge clk); drive(1, 4'd3, 8'hA5); #1;
    check("wr3_ready", req_ready, 1);
    @(negedge clk); drive(0, 4'd3, 8'h00); #1;
    check("rd3_ready", req_ready, 1);
    @(negedge clk); idle(); #1;
    check("rd3_lat_valid", rsp_valid, 0);
    @(negedge clk); #1;
    check("rd3_valid", rsp_valid, 1);
    check("rd3_data", rsp_rdata, 8'hA5);

    // Back-to-back: 16 writes of addr^0x5A, then 16 reads at one per cycle.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); drive(1, 4'(i), 8'(i) ^ 8'h5A); #1;
      check("b2b_wr_ready", req_ready, 1);
    end
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i < 16) drive(0, 4'(i), 8'h00);
      else        idle();
      #1;
      if (i < 16) check("b2b_rd_ready", req_ready, 1);
      if (i >= 2) begin
        check("b2b_rsp_valid", rsp_valid, 1);
        check("b2b_rsp_data", rsp_rdata, 8'(i - 2) ^ 8'h5A);
      end
    end
    @(negedge clk); #1;
    check("b2b_drained", rsp_valid, 0);

    // Backpressure: reads of 1, 2, 3 with rsp_ready low.
    @(negedge clk); rsp_ready = 1'b0; drive(0, 4'd1, 8'h00); #1;
    check("bp_ready_a1", req_ready, 1);
    @(negedge clk); drive(0, 4'd2, 8'h00); #1;
    check("bp_ready_a2", req_ready, 1);
    check("bp_valid_a2", rsp_valid, 0);
    @(negedge clk); drive(0, 4'd3, 8'h00); #1;
    check("bp_stall_1", req_ready, 0);
    check("bp_head_1", rsp_rdata, 8'h5B);
    @(negedge clk); #1;
    check("bp_stall_2", req_ready, 0);
    check("bp_valid_full", rsp_valid, 1);
    check("bp_head_full", rsp_rdata, 8'h5B);
    rsp_ready = 1'b1; #1;
    check("bp_release_ready", req_ready, 1);
    @(negedge clk); idle(); #1;
    check("bp_rsp2_valid", rsp_valid, 1);
    check("bp_rsp2_data", rsp_rdata, 8'h58);
    @(negedge clk); #1;
    check("bp_rsp3_valid", rsp_valid, 1);
    check("bp_rsp3_data", rsp_rdata, 8'h59);
    @(negedge clk); #1;
    check("bp_drained", rsp_valid, 0);

    // Mixed: write 7 then read 7 every other cycle with changing data.
    for (int s = 0; s < 10; s++) begin
      @(negedge clk);
      if (s < 8) begin
        if (s % 2 == 0) drive(1, 4'd7, 8'((s / 2 + 1) * 8'h11));
        else            drive(0, 4'd7, 8'h00);
      end else begin
        idle();
      end
      #1;
      if (s < 8) check("mix_ready", req_ready, 1);
      if (s % 2 == 1 && s >= 3) begin
        check("mix_valid", rsp_valid, 1);
        check("mix_data", rsp_rdata, 8'(((s - 3) / 2 + 1) * 8'h11));
      end
      if (s % 2 == 0 && s >= 2) check("mix_no_dup", rsp_valid, 0);
    end

    // Reset mid-run with one response buffered and one read pending.
    @(negedge clk); rsp_ready = 1'b0; drive(0, 4'd7, 8'h00); #1;
    check("mr_ready_a", req_ready, 1);
    @(negedge clk); drive(0, 4'd3, 8'h00); #1;
    check("mr_ready_b", req_ready, 1);
    @(negedge clk); idle(); #1;
    check("mr_buffered", rsp_valid, 1);
    check("mr_buffered_data", rsp_rdata, 8'h44);
    rst = 1'b1; #1;
    check("mr_rst_valid", rsp_valid, 0);
    check("mr_rst_ready", req_ready, 0);
    check("mr_rst_we", ram_we, 0);
    check("mr_rst_done", init_done, 0);
    @(negedge clk); rst = 1'b0; rsp_ready = 1'b1;
    check_clear_pass();
    check("mr_no_stale", rsp_valid, 0);

    // Address 7 was cleared again.
    @(negedge clk); drive(0, 4'd7, 8'h00); #1;
    check("mr_rd7_ready", req_ready, 1);
    @(negedge clk); idle(); #1;
    check("mr_rd7_lat", rsp_valid, 0);
    @(negedge clk); #1;
    check("mr_rd7_valid", rsp_valid, 1);
    check("mr_rd7_data", rsp_rdata, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
